// File: rtl/param_seq_detector.sv
// Serial bit-pattern detector with a runtime-loadable pattern, length and overlap mode.
// Also provides an input-enable qualifier, a saturating match counter and rejection of illegal lengths.
module param_seq_detector #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = 4,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b00010110,
  parameter int                 DEF_LEN     = 5,
  parameter logic               DEF_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               inp,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               outp,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DEF_LEN_V = LEN_W'(DEF_LEN);

  logic [MAX_LEN-1:0] pat;
  logic [LEN_W-1:0]   len;
  logic               ovl;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;

  logic               len_ok;
  logic               load_ok;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic               match;

  assign len_ok  = (cfg_len != '0) && (cfg_len <= MAX_LEN_V);
  assign load_ok = cfg_load && len_ok;

  // Only the low `len` bits of the history take part in the comparison.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  assign hist_n = {hist[MAX_LEN-2:0], inp};
  assign fill_n = (fill < len) ? fill + LEN_W'(1) : len;
  assign match  = en && !load_ok && (fill_n == len) && (((hist_n ^ pat) & mask) == '0);

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat         <= DEF_PATTERN;
      len         <= DEF_LEN_V;
      ovl         <= DEF_OVERLAP;
      hist        <= '0;
      fill        <= '0;
      outp        <= 1'b0;
      match_count <= '0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= cfg_load && !len_ok;

      // An accepted load restarts detection and swallows this cycle's input bit.
      if (load_ok) begin
        pat  <= cfg_pattern;
        len  <= cfg_len;
        ovl  <= cfg_overlap;
        hist <= '0;
        fill <= '0;
        outp <= 1'b0;
      end else if (en) begin
        hist <= hist_n;
        fill <= (match && !ovl) ? '0 : fill_n;
        outp <= match;
      end else begin
        outp <= 1'b0;
      end

      if (cnt_clr) begin
        match_count <= CNT_W'(match);
      end else if (match && (match_count != '1)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule
